// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU with iterative multiply/divide: operation
// codes, FSM states and the default datapath width.
package alu_pkg;

   localparam int ALU_WIDTH_DEF = 32;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_ADD   = 4'd2,
      OP_XOR   = 4'd3,
      OP_NOR   = 4'd4,
      OP_SLTU  = 4'd5,
      OP_SUB   = 4'd6,
      OP_SLT   = 4'd7,
      OP_MULT  = 4'd8,
      OP_MULTU = 4'd9,
      OP_DIV   = 4'd10,
      OP_DIVU  = 4'd11,
      OP_MFHI  = 4'd12,
      OP_MFLO  = 4'd13
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

   function automatic logic is_iter_op(input alu_op_t op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_div_op(input alu_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input alu_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide on operand magnitudes, one bit per cycle, with the
// sign of the product/quotient/remainder restored combinationally at the end.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             is_div_i,
   input  logic             is_signed_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   x_q, x_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic [WIDTH-1:0]   mb_q, mb_d;
   logic               div_q, div_d;
   logic               neg_lo_q, neg_lo_d;
   logic               neg_hi_q, neg_hi_d;

   logic               sign_a, sign_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;

   assign sign_a    = is_signed_i & a_i[WIDTH-1];
   assign sign_b    = is_signed_i & b_i[WIDTH-1];
   // Multiply: x:y is the running product, y's LSB selects the add of mb.
   // Divide: x is the partial remainder, y shifts the dividend out and quotient in.
   assign mul_sum   = {1'b0, x_q} + (y_q[0] ? {1'b0, mb_q} : '0);
   assign div_shift = {x_q, y_q[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, mb_q});
   assign done_o    = busy_q && (cnt_q == '0);

   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no path through this block can infer a latch.
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      y_d      = y_q;
      mb_d     = mb_q;
      div_d    = div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      if (start_i) begin
         busy_d   = 1'b1;
         cnt_d    = CNT_W'(WIDTH);
         div_d    = is_div_i;
         x_d      = '0;
         y_d      = magnitude(is_div_i ? a_i : b_i, is_signed_i);
         mb_d     = magnitude(is_div_i ? b_i : a_i, is_signed_i);
         neg_lo_d = sign_a ^ sign_b;
         neg_hi_d = is_div_i ? sign_a : (sign_a ^ sign_b);
      end else if (busy_q) begin
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
               x_d = div_ge ? WIDTH'(div_shift - {1'b0, mb_q}) : div_shift[WIDTH-1:0];
               y_d = {y_q[WIDTH-2:0], div_ge};
            end else begin
               x_d = mul_sum[WIDTH:1];
               y_d = {mul_sum[0], y_q[WIDTH-1:1]};
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   // NOTE: the datapath registers carry no reset; start always loads them before they are observed.
   always_ff @(posedge clk) begin
      x_q      <= x_d;
      y_q      <= y_d;
      mb_q     <= mb_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
   end

   assign prod_fix = neg_lo_q ? -{x_q, y_q} : {x_q, y_q};
   assign hi_o     = div_q ? (neg_hi_q ? -x_q : x_q) : prod_fix[2*WIDTH-1:WIDTH];
   assign lo_o     = div_q ? (neg_lo_q ? -y_q : y_q) : prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_mdu.sv
// Registered EX-stage ALU: single-cycle logic/arith/compare ops plus iterative
// multiply/divide into HI/LO, with a valid/ready handshake for stalls.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] In1,
   input  logic [WIDTH-1:0] In2,
   input  logic [3:0]       ALUCtr,
   output logic             out_valid,
   output logic [WIDTH-1:0] ALURes,
   output logic             Zero,
   output logic             Ovf,
   output logic             DivZero
);

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             ovf_q, ovf_d;
   logic             divz_q, divz_d;
   logic             valid_q, valid_d;

   alu_op_t          op;
   logic [WIDTH-1:0] add_res, sub_res, comb_res;
   logic             comb_ovf, div_by_zero;
   logic             mdu_start, mdu_done;
   logic [WIDTH-1:0] mdu_hi, mdu_lo;

   assign op          = alu_op_t'(ALUCtr);
   assign add_res     = In1 + In2;
   assign sub_res     = In1 - In2;
   assign div_by_zero = is_div_op(op) && (In2 == '0);

   always_comb begin
      comb_res = '0;
      comb_ovf = 1'b0;
      case (op)
         OP_AND:  comb_res = In1 & In2;
         OP_OR:   comb_res = In1 | In2;
         OP_XOR:  comb_res = In1 ^ In2;
         OP_NOR:  comb_res = ~(In1 | In2);
         OP_ADD: begin
            comb_res = add_res;
            comb_ovf = (In1[WIDTH-1] == In2[WIDTH-1]) && (add_res[WIDTH-1] != In1[WIDTH-1]);
         end
         OP_SUB: begin
            comb_res = sub_res;
            comb_ovf = (In1[WIDTH-1] != In2[WIDTH-1]) && (sub_res[WIDTH-1] != In1[WIDTH-1]);
         end
         OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, $signed(In1) < $signed(In2)};
         OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, In1 < In2};
         OP_MFHI: comb_res = hi_q;
         OP_MFLO: comb_res = lo_q;
         OP_DIV, OP_DIVU: comb_res = '1;
         default: comb_res = '0;
      endcase
   end

   assign in_ready = (state_q != ST_BUSY);

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      ovf_d     = ovf_q;
      divz_d    = divz_q;
      valid_d   = 1'b0;
      mdu_start = 1'b0;
      case (state_q)
         ST_BUSY: begin
            if (mdu_done) begin
               state_d = ST_DONE;
               valid_d = 1'b1;
               res_d   = mdu_lo;
               hi_d    = mdu_hi;
               lo_d    = mdu_lo;
               ovf_d   = 1'b0;
               divz_d  = 1'b0;
            end
         end
         default: begin
            // DONE accepts exactly like IDLE so a new op can issue alongside the result.
            state_d = ST_IDLE;
            if (in_valid) begin
               if (is_iter_op(op) && !div_by_zero) begin
                  mdu_start = 1'b1;
                  state_d   = ST_BUSY;
               end else begin
                  valid_d = 1'b1;
                  res_d   = comb_res;
                  ovf_d   = comb_ovf;
                  divz_d  = div_by_zero;
                  if (div_by_zero) begin
                     hi_d = In1;
                     lo_d = '1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         ovf_q   <= 1'b0;
         divz_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         ovf_q   <= ovf_d;
         divz_q  <= divz_d;
         valid_q <= valid_d;
      end
   end

   mdu_iter #(
      .WIDTH(WIDTH)
   ) u_mdu (
      .clk        (clk),
      .rst        (rst),
      .start_i    (mdu_start),
      .is_div_i   (is_div_op(op)),
      .is_signed_i(is_signed_op(op)),
      .a_i        (In1),
      .b_i        (In2),
      .done_o     (mdu_done),
      .hi_o       (mdu_hi),
      .lo_o       (mdu_lo)
   );

   assign out_valid = valid_q;
   assign ALURes    = res_q;
   assign Zero      = (res_q == '0);
   assign Ovf       = ovf_q;
   assign DivZero   = divz_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: directed scenarios plus randomized ops checked against a
// 64-bit arithmetic reference model of the operation set and HI/LO.
module tb_alu_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in1, in2;
   logic [3:0]  ctr;
   logic        out_valid;
   logic [31:0] res;
   logic        zero, ovf, divz;

   logic        in_valid16;
   logic        in_ready16;
   logic [15:0] in1_16, in2_16;
   logic [3:0]  ctr16;
   logic        out_valid16;
   logic [15:0] res16;
   logic        zero16, ovf16, divz16;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .In1(in1), .In2(in2), .ALUCtr(ctr), .out_valid(out_valid),
      .ALURes(res), .Zero(zero), .Ovf(ovf), .DivZero(divz)
   );

   alu_mdu #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .In1(in1_16), .In2(in2_16), .ALUCtr(ctr16), .out_valid(out_valid16),
      .ALURes(res16), .Zero(zero16), .Ovf(ovf16), .DivZero(divz16)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op and wait for its result; lat = edges after the accept edge.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic o, output logic dz,
                        output logic z, output int lat);
      in_valid = 1'b1;
      ctr      = op;
      in1      = a;
      in2      = b;
      tick();
      in_valid = 1'b0;
      lat      = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      if (lat >= 100) begin
         tests++;
         fails++;
         $display("FAIL timeout: op %0d gave no out_valid within %0d cycles", op, lat);
      end
      r  = res;
      o  = ovf;
      dz = divz;
      z  = zero;
   endtask

   // Reference: MIPS semantics computed with 64-bit integer arithmetic.
   task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic o, output logic dz, output int lat);
      longint      sa, sb, t;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      r   = '0;
      o   = 1'b0;
      dz  = 1'b0;
      lat = 0;
      case (op)
         4'd0: r = a & b;
         4'd1: r = a | b;
         4'd2: begin r = a + b; t = sa + sb; o = (t != longint'($signed(r))); end
         4'd3: r = a ^ b;
         4'd4: r = ~(a | b);
         4'd5: r = (a < b) ? 32'd1 : 32'd0;
         4'd6: begin r = a - b; t = sa - sb; o = (t != longint'($signed(r))); end
         4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
         4'd8: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 33; end
         4'd9: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 33; end
         4'd10, 4'd11: begin
            if (b == 32'd0) begin
               dz = 1'b1; m_lo = '1; m_hi = a;
            end else if (op == 4'd10) begin
               t = sa / sb; m_lo = 32'(t);
               t = sa % sb; m_hi = 32'(t);
               lat = 33;
            end else begin
               m_lo = a / b; m_hi = a % b; lat = 33;
            end
            r = m_lo;
         end
         4'd12: r = m_hi;
         4'd13: r = m_lo;
         default: r = '0;
      endcase
   endtask

   task automatic test_reset();
      logic [31:0] r;
      logic o, dz, z;
      int lat;
      rst = 1'b1; in_valid = 1'b0; ctr = '0; in1 = '0; in2 = '0;
      in_valid16 = 1'b0; ctr16 = '0; in1_16 = '0; in2_16 = '0;
      tick(); tick();
      rst = 1'b0;
      tests++;
      if ({in_ready, out_valid, zero, ovf, divz} !== 5'b10100 || res !== 32'd0) begin
         fails++;
         $display("FAIL reset_state: got rdy/vld/z/ovf/dz=%b res=%h want 10100 res=0",
                  {in_ready, out_valid, zero, ovf, divz}, res);
      end
      m_hi = '0; m_lo = '0;
      do_op(4'd12, 32'd0, 32'd0, r, o, dz, z, lat);
      tests++;
      if (r !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h want 0", r); end
      do_op(4'd13, 32'd0, 32'd0, r, o, dz, z, lat);
      tests++;
      if (r !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h want 0", r); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  codes [5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
      logic [31:0] exp   [5] = '{32'd0, 32'hC, 32'hC, 32'hFFFFFFFC, 32'd1};
      in_valid = 1'b1; in1 = 32'd4; in2 = 32'd8;
      for (int i = 0; i < 5; i++) begin
         ctr = codes[i];
         tick();
         tests++;
         if (out_valid !== 1'b1 || in_ready !== 1'b1 || res !== exp[i]) begin
            fails++;
            $display("FAIL b2b_op%0d: got vld=%b rdy=%b res=%h want vld=1 rdy=1 res=%h",
                     codes[i], out_valid, in_ready, res, exp[i]);
         end
      end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_logic_patterns();
      logic [31:0] r;
      logic o, dz, z;
      int lat;
      do_op(4'd0, 32'h44444444, 32'h88888888, r, o, dz, z, lat);
      tests++;
      if (r !== 32'd0 || z !== 1'b1) begin fails++; $display("FAIL and_zero: got %h z=%b want 0 z=1", r, z); end
      do_op(4'd1, 32'h44444444, 32'h88888888, r, o, dz, z, lat);
      tests++;
      if (r !== 32'hCCCCCCCC || z !== 1'b0) begin fails++; $display("FAIL or: got %h z=%b want cccccccc z=0", r, z); end
      do_op(4'd7, 32'h99999999, 32'h88888888, r, o, dz, z, lat);
      tests++;
      if (r !== 32'd0) begin fails++; $display("FAIL slt_neg: got %h want 0", r); end
      do_op(4'd5, 32'h99999999, 32'h88888888, r, o, dz, z, lat);
      tests++;
      if (r !== 32'd0) begin fails++; $display("FAIL sltu: got %h want 0", r); end
   endtask

   task automatic test_overflow();
      logic [31:0] r;
      logic o, dz, z;
      int lat;
      do_op(4'd2, 32'h7FFFFFFF, 32'd1, r, o, dz, z, lat);
      tests++;
      if (r !== 32'h80000000 || o !== 1'b1) begin fails++; $display("FAIL add_ovf: got %h ovf=%b want 80000000 ovf=1", r, o); end
      do_op(4'd6, 32'h80000000, 32'd1, r, o, dz, z, lat);
      tests++;
      if (r !== 32'h7FFFFFFF || o !== 1'b1) begin fails++; $display("FAIL sub_ovf: got %h ovf=%b want 7fffffff ovf=1", r, o); end
      do_op(4'd2, 32'hFFFFFFFF, 32'd1, r, o, dz, z, lat);
      tests++;
      if (r !== 32'd0 || o !== 1'b0 || z !== 1'b1) begin fails++; $display("FAIL add_wrap: got %h ovf=%b z=%b want 0 ovf=0 z=1", r, o, z); end
   endtask

   task automatic test_mult();
      logic [31:0] r;
      logic o, dz, z;
      int lat;
      bit busy_ok;
      in_valid = 1'b1; ctr = 4'd8; in1 = 32'd7; in2 = 32'hFFFFFFFD;
      tick();
      in_valid = 1'b0;
      busy_ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_ok = 1'b0;
         tick();
      end
      tests++;
      if (!busy_ok) begin fails++; $display("FAIL mult_busy: in_ready/out_valid not low for 32 cycles, got ok=%b want 1", busy_ok); end
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL mult_early: got out_valid=%b at accept+32 want 0", out_valid); end
      tick();
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || res !== 32'hFFFFFFEB || ovf !== 1'b0) begin
         fails++;
         $display("FAIL mult_result: got vld=%b rdy=%b res=%h ovf=%b want 1 1 ffffffeb 0", out_valid, in_ready, res, ovf);
      end
      do_op(4'd12, 32'd0, 32'd0, r, o, dz, z, lat);
      tests++;
      if (r !== 32'hFFFFFFFF || lat !== 0) begin fails++; $display("FAIL mult_mfhi: got %h lat=%0d want ffffffff lat=0", r, lat); end
   endtask

   task automatic test_div();
      logic [31:0] r;
      logic o, dz, z;
      int lat;
      do_op(4'd10, 32'hFFFFFFF9, 32'd2, r, o, dz, z, lat);
      tests++;
      if (r !== 32'hFFFFFFFD || lat !== 33 || dz !== 1'b0) begin fails++; $display("FAIL div_neg: got %h lat=%0d dz=%b want fffffffd lat=33 dz=0", r, lat, dz); end
      do_op(4'd12, 32'd0, 32'd0, r, o, dz, z, lat);
      tests++;
      if (r !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_rem: got %h want ffffffff", r); end
      do_op(4'd11, 32'd5, 32'd0, r, o, dz, z, lat);
      tests++;
      if (r !== 32'hFFFFFFFF || dz !== 1'b1 || lat !== 0) begin fails++; $display("FAIL divu_zero: got %h dz=%b lat=%0d want ffffffff dz=1 lat=0", r, dz, lat); end
      do_op(4'd12, 32'd0, 32'd0, r, o, dz, z, lat);
      tests++;
      if (r !== 32'd5 || dz !== 1'b0) begin fails++; $display("FAIL divzero_hi: got %h dz=%b want 5 dz=0", r, dz); end
      do_op(4'd10, 32'h80000000, 32'hFFFFFFFF, r, o, dz, z, lat);
      tests++;
      if (r !== 32'h80000000 || o !== 1'b0) begin fails++; $display("FAIL div_minneg: got %h ovf=%b want 80000000 ovf=0", r, o); end
      do_op(4'd12, 32'd0, 32'd0, r, o, dz, z, lat);
      tests++;
      if (r !== 32'd0) begin fails++; $display("FAIL div_minneg_hi: got %h want 0", r); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] r;
      logic o, dz, z;
      int lat;
      int seen;
      in_valid = 1'b1; ctr = 4'd9; in1 = 32'h12345678; in2 = 32'd9;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL abort_state: got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid === 1'b1) seen++;
      end
      tests++;
      if (seen != 0) begin fails++; $display("FAIL abort_quiet: got %0d out_valid pulses want 0", seen); end
      m_hi = '0; m_lo = '0;
      do_op(4'd13, 32'd0, 32'd0, r, o, dz, z, lat);
      tests++;
      if (r !== 32'd0) begin fails++; $display("FAIL abort_lo: got %h want 0", r); end
   endtask

   task automatic test_random();
      logic [31:0] a, b, r, er;
      logic o, dz, z, eo, edz;
      logic [3:0] op;
      int lat, elat;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_hi = '0; m_lo = '0;
      for (int i = 0; i < 300; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: begin a = 32'($urandom_range(0, 20)) - 32'd10; b = 32'($urandom_range(0, 20)) - 32'd10; end
            3: begin a = 32'h7FFFFFFF - 32'($urandom_range(0, 3)); b = 32'($urandom_range(0, 3)); end
            default: ;
         endcase
         model_op(op, a, b, er, eo, edz, elat);
         do_op(op, a, b, r, o, dz, z, lat);
         tests++;
         if (r !== er || o !== eo || dz !== edz || z !== (er == 32'd0) || lat !== elat) begin
            fails++;
            $display("FAIL rand_op%0d a=%h b=%h: got res=%h ovf=%b dz=%b z=%b lat=%0d want res=%h ovf=%b dz=%b lat=%0d",
                     op, a, b, r, o, dz, z, lat, er, eo, edz, elat);
         end
      end
   endtask

   task automatic test_width16();
      logic [3:0]  codes [5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
      logic [15:0] exp   [5] = '{16'd0, 16'hC, 16'hC, 16'hFFFC, 16'd1};
      int lat;
      in_valid16 = 1'b1; in1_16 = 16'd4; in2_16 = 16'd8;
      for (int i = 0; i < 5; i++) begin
         ctr16 = codes[i];
         tick();
         tests++;
         if (out_valid16 !== 1'b1 || in_ready16 !== 1'b1 || res16 !== exp[i] || zero16 !== (exp[i] == 16'd0)) begin
            fails++;
            $display("FAIL w16_op%0d: got vld=%b rdy=%b res=%h z=%b want vld=1 rdy=1 res=%h",
                     codes[i], out_valid16, in_ready16, res16, zero16, exp[i]);
         end
      end
      ctr16 = 4'd8; in1_16 = 16'd7; in2_16 = 16'hFFFD;
      tick();
      in_valid16 = 1'b0;
      lat = 0;
      while (out_valid16 !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      tests++;
      if (lat !== 17 || res16 !== 16'hFFEB || ovf16 !== 1'b0 || divz16 !== 1'b0) begin
         fails++;
         $display("FAIL w16_mult: got res=%h lat=%0d ovf=%b dz=%b want ffeb lat=17 ovf=0 dz=0", res16, lat, ovf16, divz16);
      end
      in_valid16 = 1'b1; ctr16 = 4'd12;
      tick();
      in_valid16 = 1'b0;
      tests++;
      if (out_valid16 !== 1'b1 || res16 !== 16'hFFFF) begin fails++; $display("FAIL w16_mfhi: got vld=%b res=%h want 1 ffff", out_valid16, res16); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_logic_patterns();
      test_overflow();
      test_mult();
      test_div();
      test_reset_abort();
      test_random();
      test_width16();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached after %0d tests", tests);
      $fatal(1, "watchdog");
   end

endmodule
